// File: rtl/wave_gen_multi.sv
// Multi-channel test-pattern generator: per-channel up/down counter, LFSR or four-state source.
// Samples are registered one edge after the source state; there is no backpressure, enable only pauses.
module wave_gen_multi #(
  parameter int          WIDTH     = 8,
  parameter int          CHANNELS  = 2,
  parameter logic [31:0] SEED      = 32'h0000_0001,
  parameter int          XZ_PERIOD = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [2*CHANNELS-1:0]        mode,
  input  logic                         load,
  input  logic [WIDTH-1:0]             load_value,
  output wire  [CHANNELS*WIDTH-1:0]    data_out,
  output logic                         valid,
  output logic [CHANNELS-1:0]          xz_flag,
  output logic [31:0]                  cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [7:0]  INJ_LAST  = 8'(XZ_PERIOD - 1);

  function automatic logic [31:0] seed_of(input int ch);
    logic [31:0] s;
    s = SEED + 32'(ch);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  state_t                            state_q, state_d;
  logic [CHANNELS-1:0][WIDTH-1:0]    data_q, data_d;
  logic [CHANNELS-1:0]               zsel_q, zsel_d;
  logic [CHANNELS-1:0]               xz_q, xz_d;
  logic                              valid_q, valid_d;
  logic [31:0]                       cycle_count_q, cycle_count_d;
  logic [CHANNELS-1:0][WIDTH-1:0]    up_q, up_d;
  logic [CHANNELS-1:0][WIDTH-1:0]    dn_q, dn_d;
  logic [CHANNELS-1:0][31:0]         lfsr_q, lfsr_d;
  logic [CHANNELS-1:0][7:0]          inj_q, inj_d;
  logic [CHANNELS-1:0]               phase_q, phase_d;
  logic                              run;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      data_q        <= '0;
      zsel_q        <= '0;
      xz_q          <= '0;
      valid_q       <= 1'b0;
      cycle_count_q <= '0;
      up_q          <= '0;
      dn_q          <= '1;
      inj_q         <= '0;
      phase_q       <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        lfsr_q[ch] <= seed_of(ch);
      end
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      zsel_q        <= zsel_d;
      xz_q          <= xz_d;
      valid_q       <= valid_d;
      cycle_count_q <= cycle_count_d;
      up_q          <= up_d;
      dn_q          <= dn_d;
      lfsr_q        <= lfsr_d;
      inj_q         <= inj_d;
      phase_q       <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable)  state_d = S_RUN;
      S_RUN:   if (!enable) state_d = S_PAUSE;
      S_PAUSE: if (enable)  state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // An edge is a RUN edge when the FSM is in (or entering) RUN on that edge.
  assign run = (state_d == S_RUN);

  always_comb begin
    data_d        = data_q;
    zsel_d        = zsel_q;
    xz_d          = xz_q;
    valid_d       = run;
    cycle_count_d = cycle_count_q;
    up_d          = up_q;
    dn_d          = dn_q;
    lfsr_d        = lfsr_q;
    inj_d         = inj_q;
    phase_d       = phase_q;

    if (run) begin
      if (cycle_count_q != 32'hFFFF_FFFF) begin
        cycle_count_d = cycle_count_q + 32'd1;
      end
      for (int ch = 0; ch < CHANNELS; ch++) begin
        xz_d[ch]   = 1'b0;
        zsel_d[ch] = 1'b0;
        case (mode[2*ch +: 2])
          2'd0: data_d[ch] = up_q[ch];
          2'd1: data_d[ch] = dn_q[ch];
          2'd2: data_d[ch] = lfsr_q[ch][WIDTH-1:0];
          default: begin
            if (inj_q[ch] == INJ_LAST) begin
              xz_d[ch] = 1'b1;
              // Z cannot live in a flop, so it is flagged here and driven at the port.
              if (phase_q[ch]) begin
                data_d[ch] = '0;
                zsel_d[ch] = 1'b1;
              end else begin
                data_d[ch] = {WIDTH{1'bx}};
              end
            end else begin
              data_d[ch] = lfsr_q[ch][WIDTH-1:0];
            end
          end
        endcase

        up_d[ch]   = up_q[ch] + 1'b1;
        dn_d[ch]   = dn_q[ch] - 1'b1;
        lfsr_d[ch] = {1'b0, lfsr_q[ch][31:1]} ^ (lfsr_q[ch][0] ? LFSR_POLY : 32'd0);
        if (inj_q[ch] == INJ_LAST) begin
          inj_d[ch]   = 8'd0;
          phase_d[ch] = ~phase_q[ch];
        end else begin
          inj_d[ch] = inj_q[ch] + 8'd1;
        end
      end
    end

    // Load overrides the counter advance in every state.
    if (load) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        up_d[ch] = load_value;
        dn_d[ch] = load_value;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign data_out[g*WIDTH +: WIDTH] = zsel_q[g] ? {WIDTH{1'bz}} : data_q[g];
  end

  assign valid       = valid_q;
  assign xz_flag     = xz_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_wave_gen_multi.sv
// Self-checking bench for wave_gen_multi: reference model pushes expected samples, DUT output pops them.
module tb_wave_gen_multi;
  localparam int CH = 2;
  localparam int XP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  mode;
  logic        load;
  logic [7:0]  load_value;
  wire  [15:0] data_out;
  logic        valid;
  logic [1:0]  xz_flag;
  logic [31:0] cycle_count;

  wave_gen_multi dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .load(load),
    .load_value(load_value), .data_out(data_out), .valid(valid),
    .xz_flag(xz_flag), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dat;
    logic [1:0]  xz;
    logic [31:0] cc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        probe;
  logic        four_state;

  logic [7:0]  m_up[CH];
  logic [7:0]  m_dn[CH];
  logic [31:0] m_lfsr[CH];
  int          m_inj[CH];
  logic        m_ph[CH];
  logic [31:0] m_cc;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_up[c]   = 8'h00;
      m_dn[c]   = 8'hFF;
      m_lfsr[c] = 32'd1 + 32'(c);
      m_inj[c]  = 0;
      m_ph[c]   = 1'b0;
    end
    m_cc = 32'd0;
    exp_q.delete();
  endtask

  // Drive one edge's inputs and record what the upcoming edge must produce.
  task automatic drive(input logic en, input logic [3:0] md, input logic ld, input logic [7:0] lv);
    exp_t e;
    enable     = en;
    mode       = md;
    load       = ld;
    load_value = lv;
    if (en) begin
      e.dat = 16'h0;
      e.xz  = 2'b00;
      if (m_cc != 32'hFFFF_FFFF) m_cc = m_cc + 32'd1;
      e.cc = m_cc;
      for (int c = 0; c < CH; c++) begin
        case (md[2*c +: 2])
          2'd0: e.dat[c*8 +: 8] = m_up[c];
          2'd1: e.dat[c*8 +: 8] = m_dn[c];
          2'd2: e.dat[c*8 +: 8] = m_lfsr[c][7:0];
          default: begin
            if (m_inj[c] == XP - 1) begin
              e.xz[c] = 1'b1;
              e.dat[c*8 +: 8] = m_ph[c] ? 8'hzz : 8'hxx;
            end else begin
              e.dat[c*8 +: 8] = m_lfsr[c][7:0];
            end
          end
        endcase
        if (m_inj[c] == XP - 1) begin
          m_inj[c] = 0;
          m_ph[c]  = ~m_ph[c];
        end else begin
          m_inj[c] = m_inj[c] + 1;
        end
        m_up[c]   = m_up[c] + 8'd1;
        m_dn[c]   = m_dn[c] - 8'd1;
        m_lfsr[c] = (m_lfsr[c] >> 1) ^ (m_lfsr[c][0] ? 32'h8020_0003 : 32'd0);
      end
      exp_q.push_back(e);
    end
    if (ld) begin
      for (int c = 0; c < CH; c++) begin
        m_up[c] = lv;
        m_dn[c] = lv;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; enable = 1'b0; load = 1'b0; mode = 4'h0; load_value = 8'h00;
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; load = 1'b1; mode = 4'h0; load_value = 8'h55;
    model_reset();
    repeat (2) tick();
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_cmp++; if (data_out !== 16'h0000) begin n_bad++; $display("FAIL reset_data: got %h want 0000", data_out); end
    n_cmp++; if (xz_flag !== 2'b00) begin n_bad++; $display("FAIL reset_xz: got %b want 00", xz_flag); end
    n_cmp++; if (cycle_count !== 32'd0) begin n_bad++; $display("FAIL reset_cc: got %0d want 0", cycle_count); end
  endtask

  task automatic test_count_up();
    exp_t e;
    apply_reset();
    for (int i = 1; i <= 257; i++) begin
      drive(1'b1, 4'b0000, 1'b0, 8'h00);
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL up_valid[%0d]: got %b want 1", i, valid); end
      n_cmp++; if (data_out !== e.dat || xz_flag !== e.xz) begin n_bad++; $display("FAIL up_data[%0d]: got %h/%b want %h/%b", i, data_out, xz_flag, e.dat, e.xz); end
      n_cmp++; if (cycle_count !== e.cc) begin n_bad++; $display("FAIL up_cc[%0d]: got %0d want %0d", i, cycle_count, e.cc); end
      if (i == 256) begin
        n_cmp++; if (data_out[7:0] !== 8'hFF) begin n_bad++; $display("FAIL up_256: got %h want ff", data_out[7:0]); end
      end
    end
    n_cmp++; if (data_out[7:0] !== 8'h00) begin n_bad++; $display("FAIL up_wrap: got %h want 00", data_out[7:0]); end
    n_cmp++; if (cycle_count !== 32'd257) begin n_bad++; $display("FAIL up_cc257: got %0d want 257", cycle_count); end
  endtask

  task automatic test_count_down();
    exp_t e;
    logic [7:0] first[3];
    apply_reset();
    for (int i = 1; i <= 257; i++) begin
      drive(1'b1, 4'b0101, 1'b0, 8'h00);
      tick();
      e = exp_q.pop_front();
      if (i <= 3) first[i-1] = data_out[15:8];
      n_cmp++; if (data_out !== e.dat || valid !== 1'b1) begin n_bad++; $display("FAIL dn_data[%0d]: got %h/%b want %h/1", i, data_out, valid, e.dat); end
    end
    n_cmp++; if (first[0] !== 8'hFF || first[1] !== 8'hFE || first[2] !== 8'hFD) begin n_bad++; $display("FAIL dn_first: got %h %h %h want ff fe fd", first[0], first[1], first[2]); end
    n_cmp++; if (data_out !== 16'hFFFF) begin n_bad++; $display("FAIL dn_wrap: got %h want ffff", data_out); end
  endtask

  task automatic test_lfsr();
    exp_t e;
    logic [15:0] s[2];
    apply_reset();
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 4'b1010, 1'b0, 8'h00);
      tick();
      e = exp_q.pop_front();
      if (i <= 2) s[i-1] = data_out;
      n_cmp++; if (data_out !== e.dat || xz_flag !== 2'b00) begin n_bad++; $display("FAIL lfsr_data[%0d]: got %h/%b want %h/00", i, data_out, xz_flag, e.dat); end
    end
    n_cmp++; if (s[0] !== 16'h0201 || s[1] !== 16'h0103) begin n_bad++; $display("FAIL lfsr_first: got %h %h want 0201 0103", s[0], s[1]); end
  endtask

  task automatic test_xz();
    exp_t e;
    int flagged;
    flagged = 0;
    apply_reset();
    for (int i = 1; i <= 12; i++) begin
      drive(1'b1, 4'b1111, 1'b0, 8'h00);
      tick();
      e = exp_q.pop_front();
      if (xz_flag == 2'b11) flagged++;
      for (int c = 0; c < CH; c++) begin
        n_cmp++;
        if (e.xz[c]) begin
          if (xz_flag[c] !== 1'b1 || (four_state && data_out[c*8 +: 8] !== e.dat[c*8 +: 8])) begin
            n_bad++; $display("FAIL xz_inject[%0d] ch%0d: got %h/%b want %h/1", i, c, data_out[c*8 +: 8], xz_flag[c], e.dat[c*8 +: 8]);
          end
        end else if (data_out[c*8 +: 8] !== e.dat[c*8 +: 8] || xz_flag[c] !== 1'b0) begin
          n_bad++; $display("FAIL xz_lfsr[%0d] ch%0d: got %h/%b want %h/0", i, c, data_out[c*8 +: 8], xz_flag[c], e.dat[c*8 +: 8]);
        end
      end
    end
    n_cmp++; if (flagged !== 3) begin n_bad++; $display("FAIL xz_count: got %0d want 3", flagged); end
  endtask

  task automatic test_pause_load();
    exp_t e;
    apply_reset();
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 4'b0000, 1'b0, 8'h00);
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (data_out !== e.dat) begin n_bad++; $display("FAIL pl_run[%0d]: got %h want %h", i, data_out, e.dat); end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b0000, (i == 3), 8'h80);
      tick();
      n_cmp++; if (valid !== 1'b0 || data_out[7:0] !== 8'h05 || cycle_count !== 32'd6) begin
        n_bad++; $display("FAIL pl_pause[%0d]: got v=%b d=%h cc=%0d want v=0 d=05 cc=6", i, valid, data_out[7:0], cycle_count);
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'b0000, 1'b0, 8'h00);
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (data_out !== e.dat || valid !== 1'b1 || cycle_count !== e.cc) begin
        n_bad++; $display("FAIL pl_resume[%0d]: got %h/%b/%0d want %h/1/%0d", i, data_out, valid, cycle_count, e.dat, e.cc);
      end
      n_cmp++; if (data_out[7:0] !== 8'h80 + 8'(i)) begin n_bad++; $display("FAIL pl_load[%0d]: got %h want %h", i, data_out[7:0], 8'h80 + 8'(i)); end
    end
  endtask

  task automatic test_mixed_modes();
    exp_t e;
    apply_reset();
    for (int i = 1; i <= 10; i++) begin
      if (i <= 6) drive(1'b1, 4'b1011, 1'b0, 8'h00);
      else        drive(1'b1, 4'b0100, (i == 7), 8'h40);
      tick();
      e = exp_q.pop_front();
      for (int c = 0; c < CH; c++) begin
        n_cmp++;
        if (e.xz[c]) begin
          if (xz_flag[c] !== 1'b1) begin n_bad++; $display("FAIL mix_inject[%0d] ch%0d: got %b want 1", i, c, xz_flag[c]); end
        end else if (data_out[c*8 +: 8] !== e.dat[c*8 +: 8] || xz_flag[c] !== 1'b0) begin
          n_bad++; $display("FAIL mix_data[%0d] ch%0d: got %h/%b want %h/0", i, c, data_out[c*8 +: 8], xz_flag[c], e.dat[c*8 +: 8]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 4'b0000, 1'b0, 8'h00);
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (data_out !== e.dat) begin n_bad++; $display("FAIL ar_run[%0d]: got %h want %h", i, data_out, e.dat); end
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (data_out !== 16'h0000 || valid !== 1'b0 || cycle_count !== 32'd0 || xz_flag !== 2'b00) begin
      n_bad++; $display("FAIL ar_mid: got d=%h v=%b cc=%0d xz=%b want 0/0/0/0", data_out, valid, cycle_count, xz_flag);
    end
    #1 reset = 1'b0;
    model_reset();
    drive(1'b1, 4'b0000, 1'b0, 8'h00);
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (data_out !== e.dat || cycle_count !== e.cc) begin n_bad++; $display("FAIL ar_first: got %h/%0d want %h/%0d", data_out, cycle_count, e.dat, e.cc); end
    n_cmp++; if (data_out[7:0] !== 8'h00 || valid !== 1'b1) begin n_bad++; $display("FAIL ar_first00: got %h/%b want 00/1", data_out[7:0], valid); end
  endtask

  initial begin
    probe = 1'bx;
    four_state = $isunknown(probe);
    test_reset();
    test_count_up();
    test_count_down();
    test_lfsr();
    test_xz();
    test_pause_load();
    test_mixed_modes();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wave_gen_multi.md
WAVE_GEN_MULTI -- requirements
Module: wave_gen_multi

Interface
REQ-001 Parameter WIDTH, default 8, bits per channel sample, legal range 1..32.
REQ-002 Parameter CHANNELS, default 2, number of independent generator channels, legal range 1..16.
REQ-003 Parameter SEED, default 32'h0000_0001, base LFSR seed.
REQ-004 Parameter XZ_PERIOD, default 4, four-state injection interval in RUN cycles, legal range 2..255.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  reset is asynchronous and active-high.
REQ-007 enable  input  1  1 = generate samples, 0 = pause.
REQ-008 mode  input  2*CHANNELS  per-channel source select, channel ch uses bits [2ch+1:2ch]: 0 count up, 1 count down, 2 LFSR, 3 four-state.
REQ-009 load  input  1  load all channel counters with load_value.
REQ-010 load_value  input  WIDTH  counter load value.
REQ-011 data_out  output  CHANNELS*WIDTH  registered samples, channel ch at [ch*WIDTH +: WIDTH].
REQ-012 valid  output  1  data_out updated on the last edge.
REQ-013 xz_flag  output  CHANNELS  per-channel: current sample is injected X or Z.
REQ-014 cycle_count  output  32  number of RUN cycles since reset.

Function
REQ-015 Control FSM states: IDLE, RUN, PAUSE; IDLE->RUN and PAUSE->RUN on enable=1; RUN->PAUSE on enable=0; no other transitions except reset->IDLE.
REQ-016 Per channel: up counter (WIDTH bits), down counter (WIDTH bits), 32-bit LFSR, injection counter (8 bits), injection phase bit.
REQ-017 On each rising edge in RUN: data_out[ch] <= selected source of current state, then all channel generator state advances, independent of mode.
REQ-018 Up counter +1 and down counter -1 per RUN edge, both modulo 2^WIDTH (wrap silently).
REQ-019 LFSR next = {1'b0, lfsr[31:1]} XOR (lfsr[0] ? 32'h8020_0003 : 0); LFSR source = lfsr[WIDTH-1:0].
REQ-020 Channel ch LFSR seed = SEED + ch; if the result is 0 the seed is 32'h0000_0001.
REQ-021 Injection counter counts 0..XZ_PERIOD-1 per RUN edge and wraps to 0.
REQ-022 Mode 3 sample = LFSR source, except when injection counter = XZ_PERIOD-1: all-X if phase = 0, all-Z if phase = 1; phase toggles on each such edge regardless of mode.
REQ-023 xz_flag[ch] <= 1 only on an edge where channel ch in mode 3 outputs an injected X/Z sample, else 0.
REQ-024 Mode change takes effect on the next RUN edge; no generator state is reset by a mode change.
REQ-025 valid <= 1 on every RUN edge, 0 on every IDLE/PAUSE edge.
REQ-026 In IDLE/PAUSE: data_out, xz_flag, generator state and cycle_count hold.
REQ-027 load=1 on any edge (any state): both counters of every channel <= load_value, overriding advance; LFSR, injection state and data_out update as otherwise required.
REQ-028 cycle_count +1 per RUN edge, saturating at 32'hFFFF_FFFF.

Reset
REQ-029 reset=1 forces immediately, without a clock edge: FSM IDLE, data_out 0, valid 0, xz_flag 0, cycle_count 0, up counters 0, down counters all-ones, LFSRs to seeds, injection counters 0, phases 0.
REQ-030 reset=1 dominates enable and load; first RUN edge is the first edge with reset=0 and enable=1.

Verification
REQ-031 Defaults, mode=0, enable=1 after reset: ch0 samples 8'h00, 01, 02 ... FF, then 00 on sample 257; valid=1 throughout; cycle_count=257.
REQ-032 mode=1 both channels: samples 8'hFF, FE, FD; after 256 samples wraps to FF.
REQ-033 mode=2, SEED=1: ch0 samples 8'h01, 03; ch1 (seed 2) samples 8'h02, 01.
REQ-034 mode=3, XZ_PERIOD=4: samples 1-3 LFSR, sample 4 = 8'hxx with xz_flag=1, samples 5-7 LFSR, sample 8 = 8'hzz with xz_flag=1.
REQ-035 mode=0, enable low after sample 8'h05: valid=0, data_out holds 05, cycle_count frozen; load=1 with 8'h80 in PAUSE, enable high: next samples 80, 81.
REQ-036 reset asserted between clock edges mid-RUN: data_out=0, valid=0, cycle_count=0 before next edge; after release first sample 8'h00.
